// File: rtl/pico_pkg.sv
// Shared types and helpers for the PICO-side register bank.
package pico_pkg;

    localparam int BYTE_W       = 8;
    localparam int NUM_REGS_DEF = 16;

    typedef logic [BYTE_W-1:0] byte_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        COMMIT = 2'd2
    } rb_state_t;

    function automatic logic addr_in_range(input byte_t addr, input int n);
        return (int'(addr) < n);
    endfunction

    function automatic logic is_writable(input byte_t addr, input logic [255:0] ro, input int n);
        return addr_in_range(addr, n) && (ro[addr] == 1'b0);
    endfunction

endpackage

// File: rtl/digital_reg_bank_if.sv
// Bus between the PICO stage and the register bank: strobes, pointer/data and register outputs.
interface digital_reg_bank_if
    import pico_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF
);
    logic                       msg_flag;
    logic                       sclk_stop_rstn;
    byte_t                      write_data;
    byte_t                      mux_control_signal;
    logic [NUM_REGS*BYTE_W-1:0] reg_out;
    byte_t                      readback_data;
    logic                       wr_commit;
    logic                       wr_err;
    logic                       ovr_err;
    logic                       busy;

    modport master (
        output msg_flag, sclk_stop_rstn, write_data, mux_control_signal,
        input  reg_out, readback_data, wr_commit, wr_err, ovr_err, busy
    );

    modport slave (
        input  msg_flag, sclk_stop_rstn, write_data, mux_control_signal,
        output reg_out, readback_data, wr_commit, wr_err, ovr_err, busy
    );
endinterface

// File: rtl/digital_reg_bank_sync.sv
// Multi-flop synchroniser for an asynchronous level, with a rising-edge pulse on the synchronised output.
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic iclk,
    input  logic rstn,
    input  logic async_in,
    output logic level,
    output logic rise
);
    logic [SYNC_STAGES-1:0] chain_r;
    logic                   dly_r;

    // Synchroniser chain plus one delay flop for edge detection.
    always_ff @(posedge iclk) begin
        if (!rstn) begin
            chain_r <= {SYNC_STAGES{1'b0}};
            dly_r   <= 1'b0;
        end else begin
            chain_r <= {chain_r[SYNC_STAGES-2:0], async_in};
            dly_r   <= chain_r[SYNC_STAGES-1];
        end
    end

    assign level = chain_r[SYNC_STAGES-1];
    assign rise  = chain_r[SYNC_STAGES-1] & ~dly_r;
endmodule

// File: rtl/digital_reg_bank.sv
// Configuration register bank in the iclk domain: synchronises byte strobes and commits PICO bytes.
module digital_reg_bank
    import pico_pkg::*;
#(
    parameter int                  NUM_REGS    = NUM_REGS_DEF,
    parameter int                  SYNC_STAGES = 2,
    parameter int                  SETTLE_CYC  = 1,
    parameter logic [NUM_REGS-1:0] RO_MASK     = NUM_REGS'(16'h0001)
) (
    input  logic              iclk,
    input  logic              rstn,
    digital_reg_bank_if.slave bus
);
    localparam int          IDX_W       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [255:0] RO_EXT     = 256'(RO_MASK);
    localparam byte_t       SETTLE_LOAD = byte_t'(SETTLE_CYC - 1);

    logic      flag_rise_s;
    logic      flag_lvl_unused_s;
    logic      stop_lvl_s;
    logic      stop_rise_unused_s;

    rb_state_t state_r;
    rb_state_t next_state_s;
    byte_t     cnt_r;
    byte_t     cnt_next_s;
    logic      commit_s;
    logic      ovr_set_s;

    byte_t     prev_addr_r;
    byte_t     regs_r [NUM_REGS];
    byte_t     readback_r;
    logic      wr_commit_r;
    logic      wr_err_r;
    logic      ovr_err_r;
    logic      busy_r;

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_flag_sync (
        .iclk     (iclk),
        .rstn     (rstn),
        .async_in (bus.msg_flag),
        .level    (flag_lvl_unused_s),
        .rise     (flag_rise_s)
    );

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_stop_sync (
        .iclk     (iclk),
        .rstn     (rstn),
        .async_in (bus.sclk_stop_rstn),
        .level    (stop_lvl_s),
        .rise     (stop_rise_unused_s)
    );

    // FSM state and settle counter.
    always_ff @(posedge iclk) begin
        if (!rstn) begin
            state_r <= IDLE;
            cnt_r   <= 8'd0;
        end else begin
            state_r <= next_state_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Next-state logic; transaction end overrides everything and aborts a pending commit.
    always_comb begin
        next_state_s = state_r;
        cnt_next_s   = cnt_r;
        commit_s     = 1'b0;
        ovr_set_s    = flag_rise_s && (state_r != IDLE);
        if (!stop_lvl_s) begin
            next_state_s = IDLE;
            cnt_next_s   = 8'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (flag_rise_s) begin
                        next_state_s = SETTLE;
                        cnt_next_s   = SETTLE_LOAD;
                    end else begin
                        next_state_s = IDLE;
                    end
                end
                SETTLE: begin
                    if (cnt_r == 8'd0) begin
                        commit_s     = 1'b1;
                        next_state_s = COMMIT;
                    end else begin
                        cnt_next_s   = cnt_r - 8'd1;
                    end
                end
                COMMIT:  next_state_s = IDLE;
                default: next_state_s = IDLE;
            endcase
        end
    end

    // Byte classification, register file, readback and status flags.
    always_ff @(posedge iclk) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= 8'h00;
            end
            prev_addr_r <= 8'h00;
            readback_r  <= 8'h00;
            wr_commit_r <= 1'b0;
            wr_err_r    <= 1'b0;
            ovr_err_r   <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            wr_commit_r <= 1'b0;
            wr_err_r    <= 1'b0;
            busy_r      <= (next_state_s != IDLE);
            if (ovr_set_s) begin
                ovr_err_r <= 1'b1;
            end
            readback_r <= addr_in_range(bus.mux_control_signal, NUM_REGS)
                          ? regs_r[bus.mux_control_signal[IDX_W-1:0]] : 8'h00;
            if (!stop_lvl_s) begin
                prev_addr_r <= 8'h00;
            end else if (commit_s) begin
                // Non-zero previous pointer means this byte is data for that address,
                // even when the new pointer has wrapped to 0.
                if (prev_addr_r != 8'h00) begin
                    if (is_writable(prev_addr_r, RO_EXT, NUM_REGS)) begin
                        regs_r[prev_addr_r[IDX_W-1:0]] <= bus.write_data;
                        wr_commit_r <= 1'b1;
                    end else begin
                        wr_err_r    <= 1'b1;
                    end
                end
                prev_addr_r <= bus.mux_control_signal;
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
        assign bus.reg_out[g*BYTE_W +: BYTE_W] = regs_r[g];
    end

    assign bus.readback_data = readback_r;
    assign bus.wr_commit     = wr_commit_r;
    assign bus.wr_err        = wr_err_r;
    assign bus.ovr_err       = ovr_err_r;
    assign bus.busy          = busy_r;
endmodule
